// File: rtl/phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : phase_scheduler
// Purpose  : Request-driven intersection phase controller. Latches
//            synchronized vehicle/pedestrian requests, arbitrates round-robin
//            over four phases and sequences ALLRED -> GREEN -> YELLOW with
//            tick-based timers, driving the lamp outputs from registers.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk     in   system clock
//   reset   in   asynchronous active-high reset
//   req     in   [3:0] async level requests: NS thru, EW thru, NS left, ped
//   hold    in   synchronous freeze of prescaler, timer and state
//   green   out  [1:0] {EW, NS} green lamps
//   yellow  out  [1:0] {EW, NS} yellow lamps
//   red     out  [1:0] {EW, NS} red lamps
//   left    out  [1:0] {EW, NS} left arrows (EW arrow is never lit)
//   walk    out  pedestrian walk lamp
//   phase   out  [1:0] phase currently or last served
// ============================================================================
module phase_scheduler #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 20,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       hold,
    output logic [1:0] green,
    output logic [1:0] yellow,
    output logic [1:0] red,
    output logic [1:0] left,
    output logic       walk,
    output logic [1:0] phase
);

    localparam int C_PRESC_W = $clog2(TICK_DIV);
    localparam int C_TMAX_GY = (MAX_GREEN > YELLOW) ? MAX_GREEN : YELLOW;
    localparam int C_TMAX    = (C_TMAX_GY > ALL_RED) ? C_TMAX_GY : ALL_RED;
    // One spare count so tcnt + 1 never wraps before it is compared.
    localparam int C_TCNT_W  = $clog2(C_TMAX + 2);

    typedef enum logic [1:0] {
        S_ALLRED = 2'd0,
        S_GREEN  = 2'd1,
        S_YELLOW = 2'd2
    } state_t;

    state_t                r_state, w_state_next;
    logic [C_PRESC_W-1:0]  r_presc;
    logic [C_TCNT_W-1:0]   r_tcnt, w_tcnt_inc;
    logic [3:0]            r_req_m, r_req_s;
    logic [3:0]            r_pending, w_pending_next;
    logic [1:0]            r_search_start;
    logic [1:0]            w_phase_next, w_sel, w_cand;
    logic                  w_found, w_tick, w_others, w_enter_green;
    logic [3:0]            w_cur_mask, w_green_mask, w_clear_mask;
    logic [1:0]            w_green_n, w_yellow_n, w_red_n, w_left_n;
    logic                  w_walk_n;

    always_comb begin
        w_tick     = (r_presc == C_PRESC_W'(TICK_DIV - 1)) && !hold;
        w_tcnt_inc = r_tcnt + 1'b1;
        w_cur_mask = 4'b0001 << phase;
        w_others   = |(r_pending & ~w_cur_mask);

        // Round-robin search; falls back to phase 0 when nothing is pending.
        w_sel   = 2'd0;
        w_found = 1'b0;
        w_cand  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_cand = r_search_start + 2'(k);
            if (!w_found && r_pending[w_cand]) begin
                w_sel   = w_cand;
                w_found = 1'b1;
            end
        end

        w_state_next = r_state;
        w_phase_next = phase;
        case (r_state)
            S_ALLRED: begin
                if (w_tick && (w_tcnt_inc == C_TCNT_W'(ALL_RED))) begin
                    w_state_next = S_GREEN;
                    w_phase_next = w_sel;
                end
            end
            S_GREEN: begin
                if (w_tick && w_others &&
                    ((w_tcnt_inc >= C_TCNT_W'(MAX_GREEN)) ||
                     ((w_tcnt_inc >= C_TCNT_W'(MIN_GREEN)) && !r_req_s[phase])))
                    w_state_next = S_YELLOW;
            end
            S_YELLOW: begin
                if (w_tick && (w_tcnt_inc == C_TCNT_W'(YELLOW)))
                    w_state_next = S_ALLRED;
            end
            default: w_state_next = S_ALLRED;
        endcase

        // A phase being served does not re-latch its own request; the clear
        // applied on green entry overrides a same-cycle set.
        w_enter_green  = (r_state == S_ALLRED) && (w_state_next == S_GREEN);
        w_green_mask   = (r_state == S_GREEN) ? w_cur_mask : 4'b0000;
        w_clear_mask   = w_enter_green ? (4'b0001 << w_sel) : 4'b0000;
        w_pending_next = (r_pending | (r_req_s & ~w_green_mask)) & ~w_clear_mask;

        // Lamps are decoded from the next state so they switch on the same
        // edge as the state register.
        w_green_n  = 2'b00;
        w_yellow_n = 2'b00;
        w_red_n    = 2'b11;
        w_left_n   = 2'b00;
        w_walk_n   = 1'b0;
        if (w_state_next == S_GREEN) begin
            case (w_phase_next)
                2'd0:    begin w_green_n = 2'b01; w_red_n = 2'b10; end
                2'd1:    begin w_green_n = 2'b10; w_red_n = 2'b01; end
                2'd2:    begin w_left_n  = 2'b01; w_red_n = 2'b11; end
                default: begin w_walk_n  = 1'b1;  w_red_n = 2'b11; end
            endcase
        end else if (w_state_next == S_YELLOW) begin
            case (w_phase_next)
                2'd0:    begin w_yellow_n = 2'b01; w_red_n = 2'b10; end
                2'd1:    begin w_yellow_n = 2'b10; w_red_n = 2'b01; end
                2'd2:    begin w_yellow_n = 2'b01; w_red_n = 2'b10; end
                default: begin w_red_n    = 2'b11; end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_ALLRED;
            r_presc        <= '0;
            r_tcnt         <= '0;
            r_req_m        <= 4'b0000;
            r_req_s        <= 4'b0000;
            r_pending      <= 4'b0000;
            r_search_start <= 2'd0;
            phase          <= 2'd0;
            green          <= 2'b00;
            yellow         <= 2'b00;
            red            <= 2'b11;
            left           <= 2'b00;
            walk           <= 1'b0;
        end else begin
            r_req_m   <= req;
            r_req_s   <= r_req_m;
            r_pending <= w_pending_next;
            r_state   <= w_state_next;
            phase     <= w_phase_next;
            green     <= w_green_n;
            yellow    <= w_yellow_n;
            red       <= w_red_n;
            left      <= w_left_n;
            walk      <= w_walk_n;

            if (w_enter_green)
                r_search_start <= w_sel + 2'd1;

            if (w_state_next != r_state) begin
                r_presc <= '0;
                r_tcnt  <= '0;
            end else if (!hold) begin
                r_presc <= w_tick ? '0 : r_presc + 1'b1;
                // Only an uncontested green can run past its target; it
                // saturates at MAX_GREEN.
                if (w_tick && !((r_state == S_GREEN) &&
                                (r_tcnt >= C_TCNT_W'(MAX_GREEN))))
                    r_tcnt <= w_tcnt_inc;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_phase_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_phase_scheduler
// Purpose  : Self-checking bench for phase_scheduler (TICK_DIV=4, MIN_GREEN=2,
//            MAX_GREEN=4, YELLOW=2, ALL_RED=1). Cycle indices count clock
//            edges after reset release.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phase_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       hold = 1'b0;
    logic [1:0] green, yellow, red, left, phase;
    logic       walk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    phase_scheduler #(
        .TICK_DIV (4),
        .MIN_GREEN(2),
        .MAX_GREEN(4),
        .YELLOW   (2),
        .ALL_RED  (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .hold  (hold),
        .green (green),
        .yellow(yellow),
        .red   (red),
        .left  (left),
        .walk  (walk),
        .phase (phase)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         do_reset;
        logic [3:0] req;
        int         at;
        logic [1:0] g, y, r, l;
        logic       w;
        logic [1:0] ph;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit rs, input logic [3:0] rq, input int at,
                       input logic [1:0] g, input logic [1:0] y,
                       input logic [1:0] r, input logic [1:0] l,
                       input logic w, input logic [1:0] ph);
        vec_t v;
        v.do_reset = rs; v.req = rq; v.at = at;
        v.g = g; v.y = y; v.r = r; v.l = l; v.w = w; v.ph = ph;
        vecs.push_back(v);
    endtask

    task automatic expect_out(input string nm, input logic [1:0] g,
                              input logic [1:0] y, input logic [1:0] r,
                              input logic [1:0] l, input logic w,
                              input logic [1:0] ph);
        checks++;
        if ({green, yellow, red, left, walk, phase} !== {g, y, r, l, w, ph}) begin
            errors++;
            $display("FAIL %s @cyc %0d: got g=%b y=%b r=%b l=%b w=%b ph=%b, want g=%b y=%b r=%b l=%b w=%b ph=%b",
                     nm, cyc, green, yellow, red, left, walk, phase, g, y, r, l, w, ph);
        end
    endtask

    task automatic expect_int(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    // Release lands 1 time unit after an edge; cyc then counts edges.
    task automatic do_reset(input logic [3:0] rq);
        reset = 1'b1;
        hold  = 1'b0;
        req   = rq;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc = 0;
    endtask

    task automatic advance_to(input int at);
        while (cyc < at) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    // Lamp safety invariant, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if (((green[0] | yellow[0] | left[0]) && (green[1] | yellow[1] | left[1])) ||
                (walk && (red != 2'b11)) || left[1]) begin
                errors++;
                $display("FAIL invariant @t=%0t: g=%b y=%b r=%b l=%b w=%b",
                         $time, green, yellow, red, left, walk);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  n;
        bit  done;

        // A: no requests, rest on NS through.
        add(1, 4'b0000,   0, 2'b00, 2'b00, 2'b11, 2'b00, 0, 2'd0);
        add(0, 4'b0000,   3, 2'b00, 2'b00, 2'b11, 2'b00, 0, 2'd0);
        add(0, 4'b0000,   4, 2'b01, 2'b00, 2'b10, 2'b00, 0, 2'd0);
        add(0, 4'b0000, 204, 2'b01, 2'b00, 2'b10, 2'b00, 0, 2'd0);
        // B: one-cycle EW pulse right after NS green entry -> MIN green.
        add(1, 4'b0000,   4, 2'b01, 2'b00, 2'b10, 2'b00, 0, 2'd0);
        add(0, 4'b0010,   5, 2'b01, 2'b00, 2'b10, 2'b00, 0, 2'd0);
        add(0, 4'b0000,  11, 2'b01, 2'b00, 2'b10, 2'b00, 0, 2'd0);
        add(0, 4'b0000,  12, 2'b00, 2'b01, 2'b10, 2'b00, 0, 2'd0);
        add(0, 4'b0000,  19, 2'b00, 2'b01, 2'b10, 2'b00, 0, 2'd0);
        add(0, 4'b0000,  20, 2'b00, 2'b00, 2'b11, 2'b00, 0, 2'd0);
        add(0, 4'b0000,  23, 2'b00, 2'b00, 2'b11, 2'b00, 0, 2'd0);
        add(0, 4'b0000,  24, 2'b10, 2'b00, 2'b01, 2'b00, 0, 2'd1);
        // C: NS held, EW pending -> MAX green of 16 cycles.
        add(1, 4'b0011,   3, 2'b00, 2'b00, 2'b11, 2'b00, 0, 2'd0);
        add(0, 4'b0011,  19, 2'b01, 2'b00, 2'b10, 2'b00, 0, 2'd0);
        add(0, 4'b0011,  20, 2'b00, 2'b01, 2'b10, 2'b00, 0, 2'd0);
        add(0, 4'b0011,  28, 2'b00, 2'b00, 2'b11, 2'b00, 0, 2'd0);
        add(0, 4'b0011,  32, 2'b10, 2'b00, 2'b01, 2'b00, 0, 2'd1);
        // D: all requests held -> order 0,1,2,3,0.
        add(1, 4'b1111,   4, 2'b01, 2'b00, 2'b10, 2'b00, 0, 2'd0);
        add(0, 4'b1111,  32, 2'b10, 2'b00, 2'b01, 2'b00, 0, 2'd1);
        add(0, 4'b1111,  48, 2'b00, 2'b10, 2'b01, 2'b00, 0, 2'd1);
        add(0, 4'b1111,  60, 2'b00, 2'b00, 2'b11, 2'b01, 0, 2'd2);
        add(0, 4'b1111,  76, 2'b00, 2'b01, 2'b10, 2'b00, 0, 2'd2);
        add(0, 4'b1111,  88, 2'b00, 2'b00, 2'b11, 2'b00, 1, 2'd3);
        add(0, 4'b1111, 103, 2'b00, 2'b00, 2'b11, 2'b00, 1, 2'd3);
        add(0, 4'b1111, 104, 2'b00, 2'b00, 2'b11, 2'b00, 0, 2'd3);
        add(0, 4'b1111, 112, 2'b00, 2'b00, 2'b11, 2'b00, 0, 2'd3);
        add(0, 4'b1111, 116, 2'b01, 2'b00, 2'b10, 2'b00, 0, 2'd0);

        foreach (vecs[i]) begin
            if (vecs[i].do_reset)
                do_reset(vecs[i].req);
            else
                req = vecs[i].req;
            advance_to(vecs[i].at);
            expect_out($sformatf("vec%0d", i), vecs[i].g, vecs[i].y, vecs[i].r,
                       vecs[i].l, vecs[i].w, vecs[i].ph);
        end

        // Hold asserted three cycles into phase-0 yellow, for 20 cycles.
        do_reset(4'b0011);
        advance_to(22);
        expect_out("hold_pre", 2'b00, 2'b01, 2'b10, 2'b00, 0, 2'd0);
        hold = 1'b1;
        advance_to(30);
        expect_out("hold_mid", 2'b00, 2'b01, 2'b10, 2'b00, 0, 2'd0);
        advance_to(42);
        expect_out("hold_end", 2'b00, 2'b01, 2'b10, 2'b00, 0, 2'd0);
        hold = 1'b0;
        n    = 0;
        done = 1'b0;
        for (int k = 0; k < 50 && !done; k++) begin
            advance_to(cyc + 1);
            if (yellow == 2'b01 && red == 2'b10)
                n++;
            else
                done = 1'b1;
        end
        expect_int("hold_yellow_remaining", n, 5);
        expect_out("hold_then_allred", 2'b00, 2'b00, 2'b11, 2'b00, 0, 2'd0);

        // Reset mid-green with EW and pedestrian pending.
        do_reset(4'b0000);
        advance_to(4);
        req = 4'b1010;
        advance_to(5);
        req = 4'b0000;
        advance_to(9);
        expect_out("pre_reset_green", 2'b01, 2'b00, 2'b10, 2'b00, 0, 2'd0);
        reset = 1'b1;
        #1;
        expect_out("reset_async", 2'b00, 2'b00, 2'b11, 2'b00, 0, 2'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        cyc = 0;
        advance_to(4);
        expect_out("post_reset_green", 2'b01, 2'b00, 2'b10, 2'b00, 0, 2'd0);
        advance_to(24);
        expect_out("post_reset_rest", 2'b01, 2'b00, 2'b10, 2'b00, 0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/phase_scheduler.md
# phase_scheduler

Timed, request-driven phase controller for the intersection. It latches vehicle-sensor and pedestrian requests and arbitrates among four signal phases round-robin. Each served phase runs through green, yellow and all-red clearance with tick-based timers, and the block drives per-direction lamp outputs directly. It replaces the fixed-sequence controller that feeds the lamp-driver outputs.

## Interface
- TICK_DIV, 50_000_000: clk cycles per timer tick (1 s at 50 MHz); must be ≥ 2
- MIN_GREEN, 5: minimum green, in ticks; ≥ 1
- MAX_GREEN, 20: maximum green under contention, in ticks; ≥ MIN_GREEN
- YELLOW, 3: yellow/clearance duration, in ticks; ≥ 1
- ALL_RED, 1: all-red duration, in ticks; ≥ 1
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req  in  4  asynchronous level requests: [0] NS through, [1] EW through, [2] NS left, [3] pedestrian
- hold  in  1  manual freeze; synchronous level
- green  out  2  [0] NS, [1] EW
- yellow  out  2  [0] NS, [1] EW
- red  out  2  [0] NS, [1] EW
- left  out  2  left-turn arrows: [0] NS, [1] EW (EW arrow is never lit)
- walk  out  1  pedestrian walk lamp
- phase  out  2  phase currently or last served

## Operation
- Input sync: each req bit passes through a 2-flop synchronizer to give req_s.
  - pending[i] sets when req_s[i]=1, except while in GREEN of phase i.
  - pending[i] clears on the cycle GREEN of phase i is entered; clear wins.
- States: ALLRED, GREEN, YELLOW.
  - ALLRED lasts ALL_RED ticks, then enters GREEN.
  - GREEN exits to YELLOW per the exit condition below.
  - YELLOW lasts YELLOW ticks, then returns to ALLRED.
- Phase selection, made on the ALLRED→GREEN edge:
  - Round-robin search over pending, starting at (last served + 1) mod 4.
  - If nothing is pending, select phase 0 (rest on NS through).
  - Pointer after reset: search starts at 0.
- GREEN exit condition. Let others = |pending excluding the current phase. Exit when:
  - others AND (tcnt ≥ MAX_GREEN, OR (tcnt ≥ MIN_GREEN AND req_s[phase]=0)).
  - If others=0, stay in GREEN indefinitely; tcnt saturates at MAX_GREEN.
- Lamps (fully registered):
  - ALLRED: red=11; all other lamps 0.
  - Phase 0: GREEN green=01 red=10; YELLOW yellow=01 red=10.
  - Phase 1: GREEN green=10 red=01; YELLOW yellow=10 red=01.
  - Phase 2: GREEN left=01 red=11; YELLOW yellow=01 red=10, left=00.
  - Phase 3: GREEN red=11 walk=1; YELLOW red=11 walk=0.
- Invariant: NS and EW are never simultaneously green/yellow/left; walk is never 1 unless red=11.
- hold=1: the prescaler, tcnt and state all freeze; outputs hold their values; pending still accumulates.
- Reset values: state ALLRED, tcnt 0, prescaler 0, pending 0, phase 00, red=11, all other outputs 0, search start 0.
  - Reset mid-operation forces these values immediately (asynchronous).

## Timing
- Prescaler counts 0..TICK_DIV-1 and emits a one-cycle tick at TICK_DIV-1.
  - Prescaler and tcnt restart at 0 on every state entry.
  - Each state therefore lasts exactly N×TICK_DIV cycles, where N is its tick count.
- tcnt increments on tick. The state transition is taken on the clock edge where the tick brings tcnt to the target.
- Request latency:
  - req edge to pending visible: 3 clk.
  - pending affects the GREEN exit decision on the next tick evaluation.
- Lamp outputs change on the same edge as the state change (no extra pipeline).
- GREEN exit checks happen only on tick cycles.

## Test plan
Bench parameters: TICK_DIV=4, MIN_GREEN=2, MAX_GREEN=4, YELLOW=2, ALL_RED=1.
- Reset, no requests -> red=11 for 4 cycles after release, then green=01 red=10, phase=0; holds ≥200 cycles.
- Resting in phase 0 with req[0]=0, pulse req[1] for 1 cycle -> green held 8 cycles from entry, yellow=01 8 cycles, red=11 4 cycles, then green=10 phase=1.
- req[0] held high and req[1] pending -> phase-0 green lasts exactly 16 cycles (MAX), then yellow.
- All four req held high from reset -> served phase order 0,1,2,3,0. Phase 2 shows left=01 red=11; phase 3 shows walk=1 red=11, with walk=0 during its yellow.
- hold=1 for 20 cycles, asserted 3 cycles into a yellow -> outputs and state frozen; after release, yellow persists exactly 5 more cycles.
- Assert reset mid-green with pending=1010 -> outputs red=11 in the same cycle; after release, pending=0 and phase 0 is served first.
